// File: rtl/i2c_master.sv
// i2c_master -- byte-level I2C initiator with a 4-register CSR window.
//
// Software loads DATA and PRESCALE, then writes a command to CTRL. The block
// runs START, then WRITE or READ, then STOP (each optional, always in that
// order) on open-drain scl/sda. Bit timing comes from PRESCALE: one quarter
// period lasts PRESCALE+1 clk, and every bus phase is four quarters.
//
// Optional build macro: I2C_MASTER_CLK_STRETCH_EN
//   Defined: in any quarter where SCL is released, the quarter counter holds
//            until scl reads back 1, so a target can stretch the clock.
//   Undefined: scl readback is ignored and timing is purely counter-based.
//
// Ports:
//   clk     system clock (UFM oscillator)
//   rst     asynchronous active-high reset; aborts a transfer without STOP
//   csr_a   CSR address; BASE_ADDR+0..+3 are decoded
//   csr_di  CSR write data
//   csr_we  CSR write strobe, one clk per write
//   csr_do  CSR read data, combinational, 8'h00 when not addressed
//   scl     I2C clock, driven 1'b0 or released
//   sda     I2C data, driven 1'b0 or released
//
// Register map:
//   +0 W CTRL   [0] START [1] STOP [2] WRITE [3] READ [4] NACK
//      R STATUS [7] BUSY  [6] RXNACK [5] BUS_ACTIVE
//   +1 W TX byte / R last RX byte
//   +2 PRESCALE (R/W)
//   +3 reads 8'h00, writes ignored
module i2c_master #(
  parameter logic [4:0] BASE_ADDR    = 5'h10,
  parameter logic [7:0] PRESCALE_RST = 8'h0d
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  inout  wire        scl,
  inout  wire        sda
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

  state_t     state_q, state_d, nxt;
  logic [1:0] qtr_q, qtr_d;
  logic [7:0] cnt_q, cnt_d, presc_q, presc_d, prescale_q, prescale_d;
  logic [7:0] tx_q, tx_d, rx_q, rx_d, shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic       samp_q, samp_d, rxnack_q, rxnack_d, bact_q, bact_d;
  logic       rstart_q, rstart_d;
  logic       stop_q, stop_d, wr_q, wr_d, rd_q, rd_d, nack_q, nack_d;
  logic       scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;

  logic [4:0] off;
  logic       hit, busy, stall, q_end, enter;
  logic       we_ctrl, we_data, we_pre;
  logic [8:0] half;

  // Subtracting the base keeps the decode correct for any BASE_ADDR.
  assign off     = csr_a - BASE_ADDR;
  assign hit     = (off[4:2] == 3'd0);
  assign busy    = (state_q != S_IDLE);
  assign we_ctrl = csr_we && hit && (off[1:0] == 2'd0);
  assign we_data = csr_we && hit && (off[1:0] == 2'd1);
  assign we_pre  = csr_we && hit && (off[1:0] == 2'd2);

  always_comb begin
    csr_do = 8'h00;
    if (hit) begin
      case (off[1:0])
        2'd0:    csr_do = {busy, rxnack_q, bact_q, 5'b0};
        2'd1:    csr_do = rx_q;
        2'd2:    csr_do = prescale_q;
        default: csr_do = 8'h00;
      endcase
    end
  end

`ifdef I2C_MASTER_CLK_STRETCH_EN
  // Hold the quarter while we have released SCL but someone keeps it low.
  assign stall = busy && !scl_oe_q && (scl == 1'b0);
`else
  assign stall = 1'b0;
`endif

  assign q_end = (cnt_q == presc_q);

  always_comb begin
    state_d    = state_q;
    qtr_d      = qtr_q;
    cnt_d      = cnt_q;
    presc_d    = presc_q;
    prescale_d = prescale_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    samp_d     = samp_q;
    rxnack_d   = rxnack_q;
    bact_d     = bact_q;
    rstart_d   = rstart_q;
    stop_d     = stop_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    nack_d     = nack_q;
    enter      = 1'b0;
    nxt        = S_IDLE;

    if (we_pre)           prescale_d = csr_di;
    if (we_data && !busy) tx_d       = csr_di;

    if (!busy) begin
      // NACK alone is only a modifier, not a command.
      if (we_ctrl && (csr_di[3:0] != 4'd0)) begin
        stop_d = csr_di[1];
        wr_d   = csr_di[2];
        rd_d   = csr_di[3] & ~csr_di[2];   // WRITE wins over READ
        nack_d = csr_di[4];
        enter  = 1'b1;
        if (csr_di[0])                  nxt = S_START;
        else if (csr_di[2] | csr_di[3]) nxt = S_BIT;
        else                            nxt = S_STOP;
      end
    end else if (!stall) begin
      if (!q_end) begin
        cnt_d = cnt_q + 8'd1;
      end else begin
        cnt_d = 8'd0;
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd1) samp_d = sda;
        if (qtr_q == 2'd3) begin
          case (state_q)
            S_START: begin
              bact_d = 1'b1;
              if (wr_q | rd_q) begin enter = 1'b1; nxt = S_BIT;  end
              else if (stop_q) begin enter = 1'b1; nxt = S_STOP; end
              else state_d = S_IDLE;
            end
            S_BIT: begin
              shift_d = {shift_q[6:0], samp_q};
              enter   = 1'b1;
              if (bit_q == 3'd0) nxt = S_ACK;
              else begin
                nxt   = S_BIT;
                bit_d = bit_q - 3'd1;
              end
            end
            S_ACK: begin
              if (wr_q) rxnack_d = samp_q;
              if (rd_q) rx_d     = shift_q;
              if (stop_q) begin enter = 1'b1; nxt = S_STOP; end
              else state_d = S_IDLE;
            end
            S_STOP: begin
              bact_d  = 1'b0;
              state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    end

    // Phase entry: restart the quarter counter and resample PRESCALE.
    if (enter) begin
      state_d = nxt;
      qtr_d   = 2'd0;
      cnt_d   = 8'd0;
      presc_d = prescale_q;
      if (nxt == S_START) rstart_d = bact_q;
      if (nxt == S_BIT && state_q != S_BIT) begin
        bit_d   = 3'd7;
        shift_d = tx_q;
      end
    end

    // Pin drive is computed from the next state so the registered outputs
    // line up exactly with the quarter boundaries.
    half     = ({1'b0, presc_d} + 9'd1) >> 1;
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    case (state_d)
      S_IDLE: scl_oe_d = bact_d;
      S_START: begin
        case (qtr_d)
          // Repeated start: keep SCL low for the first half of q0 so SDA
          // can be released before SCL rises.
          2'd0:    scl_oe_d = rstart_d && ({1'b0, cnt_d} < half);
          2'd1:    sda_oe_d = 1'b1;
          default: begin scl_oe_d = 1'b1; sda_oe_d = 1'b1; end
        endcase
      end
      S_BIT: begin
        scl_oe_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
        sda_oe_d = wr_d && !shift_d[7];
      end
      S_ACK: begin
        scl_oe_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
        sda_oe_d = rd_d && !nack_d;
      end
      S_STOP: begin
        case (qtr_d)
          2'd0:    begin scl_oe_d = 1'b1; sda_oe_d = 1'b1; end
          2'd1:    sda_oe_d = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      qtr_q      <= 2'd0;
      cnt_q      <= 8'd0;
      presc_q    <= PRESCALE_RST;
      prescale_q <= PRESCALE_RST;
      tx_q       <= 8'h00;
      rx_q       <= 8'h00;
      shift_q    <= 8'h00;
      bit_q      <= 3'd0;
      samp_q     <= 1'b0;
      rxnack_q   <= 1'b0;
      bact_q     <= 1'b0;
      rstart_q   <= 1'b0;
      stop_q     <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      nack_q     <= 1'b0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      qtr_q      <= qtr_d;
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      prescale_q <= prescale_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      samp_q     <= samp_d;
      rxnack_q   <= rxnack_d;
      bact_q     <= bact_d;
      rstart_q   <= rstart_d;
      stop_q     <= stop_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      nack_q     <= nack_d;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

  assign scl = scl_oe_q ? 1'b0 : 1'bz;
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: CSR-driven transfers against a small I2C responder.
// Expected SDA bits are queued when a transfer is launched and popped on each
// checked SCL rising edge.
module tb_i2c_master;
  localparam logic [4:0] A_CTRL = 5'h10;
  localparam logic [4:0] A_DATA = 5'h11;
  localparam logic [4:0] A_PRE  = 5'h12;
  localparam logic [4:0] A_RSV  = 5'h13;
  localparam logic [4:0] A_OUT  = 5'h14;
  localparam logic [4:0] A_LOW  = 5'h0f;

  logic       clk = 1'b0, rst = 1'b1;
  logic [4:0] csr_a = 5'h0;
  logic [7:0] csr_di = 8'h0;
  logic       csr_we = 1'b0;
  logic [7:0] csr_do;
  wire        scl, sda;

  pullup (scl);
  pullup (sda);

  logic r_sda_lo = 1'b0, r_scl_lo = 1'b0;
  assign sda = r_sda_lo ? 1'b0 : 1'bz;
  assign scl = r_scl_lo ? 1'b0 : 1'bz;

  i2c_master #(.BASE_ADDR(5'h10), .PRESCALE_RST(8'h0d)) dut (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(csr_do), .scl(scl), .sda(sda)
  );

  always #5 clk = ~clk;

  int n_run = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- responder ----------------
  logic       rd_mode = 1'b0, ack_en = 1'b1;
  logic [7:0] rd_byte = 8'h00;
  logic [8:0] mask = 9'h000;
  int         rcnt = 99;
  int         stretch_idx = -1;
  logic       exp_q[$];
  logic       e;

  always @(negedge sda) if (scl === 1'b1) rcnt = 0;

  always @(posedge scl) begin
    if (rcnt <= 8 && mask[rcnt]) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk($sformatf("sda_bit%0d", rcnt), 32'(sda), 32'(e));
      end
    end
    if (rcnt < 99) rcnt++;
  end

  always @(negedge scl) begin
    if (rcnt < 8)       r_sda_lo = rd_mode && !rd_byte[7-rcnt];
    else if (rcnt == 8) r_sda_lo = !rd_mode && ack_en;
    else                r_sda_lo = 1'b0;
    if (rcnt == stretch_idx) begin
      // Master releases SCL 8 clk later; hold 50 clk beyond that.
      r_scl_lo = 1'b1;
      repeat (58) @(posedge clk);
      @(negedge clk);
      r_scl_lo = 1'b0;
    end
  end

  // ---------------- CSR helpers (called at a negedge) ----------------
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    csr_a = a; csr_di = d; csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    csr_a = a;
    #1;
    d = csr_do;
  endtask

  task automatic busy_len(output int n);
    logic [7:0] s;
    n = 0;
    for (int k = 0; k < 20000; k++) begin
      rd(A_CTRL, s);
      if (!s[7]) return;
      n++;
      @(negedge clk);
    end
    chk("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_write(input string tag, input logic [7:0] d, input logic ack,
                          input int exp_busy, input logic [7:0] exp_st);
    int n;
    logic [7:0] s;
    wr(A_DATA, d);
    rd_mode = 1'b0; ack_en = ack; mask = 9'h0ff;
    for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
    wr(A_CTRL, 8'h07);
    busy_len(n);
    chk({tag, "_busy"}, 32'(n), 32'(exp_busy));
    rd(A_CTRL, s);
    chk({tag, "_status"}, 32'(s), 32'(exp_st));
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] s;
    int n;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda", 32'(sda), 32'd1);
    rd(A_CTRL, s); chk("rst_status", 32'(s), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd(A_PRE, s);  chk("pre_rst", 32'(s), 32'h0d);
    rd(A_DATA, s); chk("rx_rst", 32'(s), 32'h00);
    rd(A_CTRL, s); chk("status_idle", 32'(s), 32'h00);
    wr(A_PRE, 8'h03);
    rd(A_PRE, s);  chk("pre_rw", 32'(s), 32'h03);
    wr(A_RSV, 8'hff);
    rd(A_RSV, s);  chk("rsv_zero", 32'(s), 32'h00);
    rd(A_OUT, s);  chk("above_window", 32'(s), 32'h00);
    rd(A_LOW, s);  chk("below_window", 32'(s), 32'h00);
    chk("idle_scl", 32'(scl), 32'd1);
    @(negedge clk);

    // START+WRITE+STOP, responder ACKs
    do_write("wr_ack", 8'hA0, 1'b1, 176, 8'h00);

    // START+READ+NACK, no STOP
    rd_mode = 1'b1; rd_byte = 8'h5C; mask = 9'h100;
    exp_q.push_back(1'b1);              // SDA released in ACK phase
    wr(A_CTRL, 8'h19);
    busy_len(n);
    chk("rd_busy", 32'(n), 32'd160);
    rd(A_DATA, s); chk("rd_data", 32'(s), 32'h5C);
    rd(A_CTRL, s); chk("rd_status", 32'(s), 32'h20);
    chk("rd_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("rd_scl_held", 32'(scl), 32'd0);
    @(negedge clk);
    rd_mode = 1'b0;

    // Writes during BUSY are ignored (also exercises repeated START)
    wr(A_DATA, 8'h3C);
    ack_en = 1'b1; mask = 9'h0ff;
    for (int i = 7; i >= 0; i--) exp_q.push_back(s[0] ^ s[0] ^ ((8'h3C >> i) & 8'h01) != 8'h00);
    wr(A_CTRL, 8'h07);
    repeat (30) @(negedge clk);
    wr(A_CTRL, 8'h02);
    wr(A_DATA, 8'hFF);
    busy_len(n);
    chk("ign_busy", 32'(n + 32), 32'd176);
    rd(A_CTRL, s); chk("ign_status", 32'(s), 32'h00);
    rd(A_DATA, s); chk("ign_rx_kept", 32'(s), 32'h5C);
    chk("ign_sb_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);

    // responder NACKs
    do_write("wr_nack", 8'hA0, 1'b0, 176, 8'h40);

    // PRESCALE = 0: one clk per quarter
    wr(A_PRE, 8'h00);
    do_write("pre0", 8'h81, 1'b1, 44, 8'h00);

    // reset mid-byte
    wr(A_PRE, 8'h03);
    wr(A_DATA, 8'hFF);
    mask = 9'h000;
    wr(A_CTRL, 8'h07);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_scl", 32'(scl), 32'd1);
    chk("abort_sda", 32'(sda), 32'd1);
    rd(A_CTRL, s); chk("abort_status", 32'(s), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd(A_PRE, s); chk("abort_pre", 32'(s), 32'h0d);
    rd(A_CTRL, s); chk("abort_status_after", 32'(s), 32'h00);
    @(negedge clk);

`ifdef I2C_MASTER_CLK_STRETCH_EN
    wr(A_PRE, 8'h03);
    stretch_idx = 4;
    do_write("stretch", 8'hA0, 1'b1, 226, 8'h00);
    stretch_idx = -1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
